// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller.
// State enum, bubble-count width and control-bundle encodings.
package pipeline_ctrl_pkg;

  localparam int BUB_W = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
    logic ifid_fl;
    logic idex_fl;
  } ctl_t;

  localparam ctl_t CTL_RST   = 7'b00000_11;
  localparam ctl_t CTL_HOLD  = 7'b00000_00;
  localparam ctl_t CTL_RUN   = 7'b11111_00;
  localparam ctl_t CTL_FLUSH = 7'b11111_11;
  localparam ctl_t CTL_BUB   = 7'b00111_01;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register controls of pipeline_ctrl.
// master: datapath side; slave: the controller.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_RegRs;
  logic [4:0]       ID_RegRt;
  logic             EX_MemRead;
  logic [4:0]       EX_RegRd;
  logic             EX_BranchTaken;
  logic             IM_Wait;
  logic             DM_Wait;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IDEX_Write;
  logic             EXMEM_Write;
  logic             MEMWB_Write;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output ID_RegRs, ID_RegRt,
    output EX_MemRead, EX_RegRd,
    output EX_BranchTaken,
    output IM_Wait, DM_Wait,
    input  PC_Write, IFID_Write,
    input  IDEX_Write, EXMEM_Write,
    input  MEMWB_Write,
    input  IFID_Flush, IDEX_Flush,
    input  StallCnt, FlushCnt
  );

  modport slave (
    input  ID_RegRs, ID_RegRt,
    input  EX_MemRead, EX_RegRd,
    input  EX_BranchTaken,
    input  IM_Wait, DM_Wait,
    output PC_Write, IFID_Write,
    output IDEX_Write, EXMEM_Write,
    output MEMWB_Write,
    output IFID_Flush, IDEX_Flush,
    output StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter, async active-low reset.
// Ports: clk, rst, inc, count[W].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
endmodule

// File: rtl/pipeline_ctrl.sv
// Load-use / branch / memory-wait stall controller.
// Ports: clk, rst (async low), bus (pipeline_ctrl_if.slave).
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned LU_BUBBLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  pipeline_ctrl_if.slave bus
);
  localparam logic [BUB_W-1:0] LU_INIT =
    BUB_W'(LU_BUBBLES - 1);
  localparam logic [BUB_W-1:0] ONE = BUB_W'(1);

  state_e           r_state;
  state_e           r_saved;
  logic [BUB_W-1:0] r_rem;

  state_e w_eff;
  logic   w_wait;
  logic   w_lu;
  logic   w_c_hold;
  logic   w_c_fl;
  logic   w_c_bub;
  ctl_t   w_ctl;

  // Leaving MEM_WAIT acts as the saved state
  // in the very same cycle.
  assign w_eff  = (r_state == MEM_WAIT) ?
                  r_saved : r_state;
  assign w_wait = bus.IM_Wait | bus.DM_Wait;
  assign w_lu   = bus.EX_MemRead &&
                  (bus.EX_RegRd != 5'd0) &&
                  ((bus.EX_RegRd == bus.ID_RegRs) ||
                   (bus.EX_RegRd == bus.ID_RegRt));

  // Mutually exclusive cycle classes.
  assign w_c_hold = rst & w_wait;
  assign w_c_fl   = rst & ~w_wait &
                    (w_eff == RUN) &
                    bus.EX_BranchTaken;
  assign w_c_bub  = rst & ~w_wait &
                    ((w_eff == LU_STALL) |
                     ((w_eff == RUN) &
                      ~bus.EX_BranchTaken & w_lu));

  always_comb begin
    w_ctl = CTL_RUN;
    unique case (1'b1)
      !rst:     w_ctl = CTL_RST;
      w_c_hold: w_ctl = CTL_HOLD;
      w_c_fl:   w_ctl = CTL_FLUSH;
      w_c_bub:  w_ctl = CTL_BUB;
      default:  w_ctl = CTL_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_saved <= RUN;
      r_rem   <= '0;
    end else begin
      unique case (1'b1)
        w_c_hold: begin
          r_state <= MEM_WAIT;
          r_saved <= w_eff;
        end
        w_c_fl: begin
          r_state <= RUN;
        end
        w_c_bub: begin
          if (w_eff == LU_STALL) begin
            if (r_rem <= ONE) begin
              r_state <= RUN;
              r_rem   <= '0;
            end else begin
              r_state <= LU_STALL;
              r_rem   <= r_rem - ONE;
            end
          end else begin
            r_state <= (LU_BUBBLES == 1) ?
                       RUN : LU_STALL;
            r_rem   <= LU_INIT;
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign bus.PC_Write    = w_ctl.pc;
  assign bus.IFID_Write  = w_ctl.ifid;
  assign bus.IDEX_Write  = w_ctl.idex;
  assign bus.EXMEM_Write = w_ctl.exmem;
  assign bus.MEMWB_Write = w_ctl.memwb;
  assign bus.IFID_Flush  = w_ctl.ifid_fl;
  assign bus.IDEX_Flush  = w_ctl.idex_fl;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~w_ctl.pc | ~w_ctl.ifid),
    .count (bus.StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_c_fl),
    .count (bus.FlushCnt)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
// Two instances: CNT_W=16 main, CNT_W=4 saturation.
module tb_pipeline_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   n_fail;

  pipeline_ctrl_if #(.CNT_W(16)) bus_a ();
  pipeline_ctrl_if #(.CNT_W(4))  bus_b ();

  pipeline_ctrl #(
    .LU_BUBBLES (2),
    .CNT_W      (16)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pipeline_ctrl #(
    .LU_BUBBLES (2),
    .CNT_W      (4)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC,IFID,IDEX,EXMEM,MEMWB,IFIDfl,IDEXfl}
  localparam logic [31:0] C_RST = 32'b0000011;
  localparam logic [31:0] C_HLD = 32'b0000000;
  localparam logic [31:0] C_RUN = 32'b1111100;
  localparam logic [31:0] C_FL  = 32'b1111111;
  localparam logic [31:0] C_BUB = 32'b0011101;

  function automatic logic [31:0] ctl_a();
    return {25'b0,
            bus_a.PC_Write, bus_a.IFID_Write,
            bus_a.IDEX_Write, bus_a.EXMEM_Write,
            bus_a.MEMWB_Write,
            bus_a.IFID_Flush, bus_a.IDEX_Flush};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_a();
    bus_a.ID_RegRs       = 5'd0;
    bus_a.ID_RegRt       = 5'd0;
    bus_a.EX_MemRead     = 1'b0;
    bus_a.EX_RegRd       = 5'd0;
    bus_a.EX_BranchTaken = 1'b0;
    bus_a.IM_Wait        = 1'b0;
    bus_a.DM_Wait        = 1'b0;
  endtask

  task automatic lu_a();
    bus_a.EX_MemRead = 1'b1;
    bus_a.EX_RegRd   = 5'd5;
    bus_a.ID_RegRs   = 5'd5;
    bus_a.ID_RegRt   = 5'd7;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    n_fail = 0;
    rst    = 1'b0;
    clr_a();
    bus_b.ID_RegRs       = 5'd0;
    bus_b.ID_RegRt       = 5'd0;
    bus_b.EX_MemRead     = 1'b0;
    bus_b.EX_RegRd       = 5'd0;
    bus_b.EX_BranchTaken = 1'b0;
    bus_b.IM_Wait        = 1'b0;
    bus_b.DM_Wait        = 1'b0;
    #2;
    chk("rst_ctl", ctl_a(), C_RST);
    chk("rst_stall", 32'(bus_a.StallCnt), 0);
    chk("rst_flush", 32'(bus_a.FlushCnt), 0);
    #1;
    rst = 1'b1;
    #1;
    chk("idle_ctl", ctl_a(), C_RUN);
    tick();

    // load-use, 2 bubbles
    lu_a();
    #1;
    chk("lu_b1", ctl_a(), C_BUB);
    tick();
    chk("lu_b2", ctl_a(), C_BUB);
    tick();
    clr_a();
    #1;
    chk("lu_done", ctl_a(), C_RUN);
    chk("lu_stall", 32'(bus_a.StallCnt), 2);
    tick();

    // x0 is never a hazard
    bus_a.EX_MemRead = 1'b1;
    #1;
    chk("x0_ctl", ctl_a(), C_RUN);
    tick();
    chk("x0_stall", 32'(bus_a.StallCnt), 2);

    // branch wins over load-use
    lu_a();
    bus_a.EX_BranchTaken = 1'b1;
    #1;
    chk("br_ctl", ctl_a(), C_FL);
    tick();
    clr_a();
    #1;
    chk("br_flush", 32'(bus_a.FlushCnt), 1);
    chk("br_stall", 32'(bus_a.StallCnt), 2);
    chk("br_run", ctl_a(), C_RUN);
    tick();

    // wait inside the bubble window
    lu_a();
    #1;
    chk("w_b1", ctl_a(), C_BUB);
    tick();
    clr_a();
    bus_a.DM_Wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("w_hold", ctl_a(), C_HLD);
      tick();
    end
    bus_a.DM_Wait = 1'b0;
    #1;
    chk("w_b2", ctl_a(), C_BUB);
    tick();
    chk("w_run", ctl_a(), C_RUN);
    chk("w_stall", 32'(bus_a.StallCnt), 7);
    tick();

    // wait beats branch
    bus_a.IM_Wait        = 1'b1;
    bus_a.EX_BranchTaken = 1'b1;
    #1;
    chk("wb_ctl", ctl_a(), C_HLD);
    tick();
    clr_a();
    #1;
    chk("wb_run", ctl_a(), C_RUN);
    chk("wb_flush", 32'(bus_a.FlushCnt), 1);
    chk("wb_stall", 32'(bus_a.StallCnt), 8);

    // reset while in MEM_WAIT
    bus_a.DM_Wait = 1'b1;
    tick();
    chk("mw_stall", 32'(bus_a.StallCnt), 9);
    rst           = 1'b0;
    bus_a.DM_Wait = 1'b0;
    #1;
    chk("mr_ctl", ctl_a(), C_RST);
    chk("mr_stall", 32'(bus_a.StallCnt), 0);
    chk("mr_flush", 32'(bus_a.FlushCnt), 0);
    rst = 1'b1;
    #1;
    chk("mr_run", ctl_a(), C_RUN);
    tick();
    chk("mr_run2", ctl_a(), C_RUN);
    chk("mr_cnt", 32'(bus_a.StallCnt), 0);

    // CNT_W=4 saturation
    bus_b.IM_Wait = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat14", 32'(bus_b.StallCnt), 14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat20", 32'(bus_b.StallCnt), 15);
    bus_b.IM_Wait = 1'b0;

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter LU_BUBBLES, 2, number of bubble cycles inserted for a load-use hazard (legal 1..3).
REQ-002 Parameter CNT_W, 16, width of each performance counter.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 ID_RegRs, ID_RegRt  in  5 each  source registers of the instruction in ID.
REQ-006 EX_MemRead  in  1  instruction in EX is a load.
REQ-007 EX_RegRd  in  5  destination register of the instruction in EX.
REQ-008 EX_BranchTaken  in  1  branch/jump in EX resolved taken.
REQ-009 IM_Wait, DM_Wait  in  1 each  instruction/data memory not ready this cycle.
REQ-010 PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write  out  1 each  pipeline register enables.
REQ-011 IFID_Flush, IDEX_Flush  out  1 each  load a bubble (NOP) into that register.
REQ-012 StallCnt, FlushCnt  out  CNT_W each  saturating performance counters.

Function
REQ-013 States: RUN, LU_STALL, MEM_WAIT; state and all counters are registers; control outputs are combinational from state, registers and inputs.
REQ-014 Load-use hazard = EX_MemRead && EX_RegRd!=0 && (EX_RegRd==ID_RegRs || EX_RegRd==ID_RegRt).
REQ-015 Priority per cycle: memory wait > branch flush > load-use > normal.
REQ-016 Memory wait (IM_Wait||DM_Wait) in any state: all five write enables 0, both flushes 0; state becomes MEM_WAIT; pre-wait state (RUN or LU_STALL) and bubble count saved.
REQ-017 In MEM_WAIT with waits deasserted: leave to saved state that same cycle and apply that state's behaviour; bubble count unchanged by the wait.
REQ-018 RUN, no wait, EX_BranchTaken=1: all enables 1, IFID_Flush=1, IDEX_Flush=1; stay RUN; load-use ignored this cycle.
REQ-019 RUN, no wait, no branch, load-use: PC_Write=0, IFID_Write=0, IDEX_Flush=1, others enable 1; go LU_STALL with remaining=LU_BUBBLES-1; if LU_BUBBLES=1 stay RUN.
REQ-020 LU_STALL, no wait: same outputs as REQ-019; decrement remaining; return to RUN after the cycle where remaining reaches 0 (exactly LU_BUBBLES bubble cycles total).
REQ-021 EX_BranchTaken during LU_STALL is not acted upon (EX holds a bubble; input is don't-care).
REQ-022 RUN, no event: all enables 1, flushes 0.
REQ-023 StallCnt +1 every cycle any of PC_Write/IFID_Write is 0 (out of reset); FlushCnt +1 per cycle REQ-018 applies; both saturate at all-ones, never wrap.

Reset
REQ-024 rst low asynchronously forces state RUN, remaining 0, saved state RUN, StallCnt=0, FlushCnt=0.
REQ-025 While rst low: all write enables 0, IFID_Flush=1, IDEX_Flush=1.
REQ-026 Reset mid-stall or mid-wait discards the pending stall; first cycle after release behaves per RUN.

Structure
REQ-027 Package pipeline_ctrl_pkg holds the state enum (RUN, LU_STALL, MEM_WAIT) and the bubble-count width constant.
REQ-028 One sub-module sat_counter (parameter W; inputs clk, rst, inc; output count) instanced twice for the performance counters.

Verification
REQ-029 Load-use: EX_MemRead=1, EX_RegRd=5, ID_RegRs=5, LU_BUBBLES=2 -> PC_Write=0, IDEX_Flush=1 for exactly 2 cycles, then RUN; StallCnt=2.
REQ-030 x0 hazard: EX_MemRead=1, EX_RegRd=0, ID_RegRt=0 -> no stall, all enables 1.
REQ-031 Branch and load-use same cycle -> IFID_Flush=IDEX_Flush=1, PC_Write=1, FlushCnt+1, StallCnt unchanged, state RUN.
REQ-032 DM_Wait asserted 3 cycles during first LU bubble -> all enables 0 for 3 cycles, then exactly 1 remaining bubble, then RUN; StallCnt=5.
REQ-033 CNT_W=4, 20 consecutive stall cycles -> StallCnt stays 15.
REQ-034 rst low in MEM_WAIT -> counters 0, flushes 1 immediately; after release with no events, all enables 1.
